tx_sample_pacer: RTL and testbench

- Sequences transmit samples from the TX sample FIFO to the modem serializer.
- Inserts a programmable idle gap between consecutive samples, using the sample-gap value and enable bit held in the system control registers.
- Counts FIFO underruns for readback through the system control IOC space.
- Sits between the TX FIFO read port and the serializer's valid/ready input.

---
 rtl/tx_sample_pacer.sv | 133 +++++++++++++
 tb/tb_tx_sample_pacer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sample_pacer.sv
// Paces TX FIFO samples into the serializer with a programmable idle gap and counts underruns.
// Optional build macro TX_PACER_ZERO_FILL_EN: on underrun, present zero samples instead of idling.
module tx_sample_pacer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned GAP_W  = 4,
    parameter int unsigned UCNT_W = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [GAP_W-1:0]  i_sample_gap,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_data,
    output logic              o_fifo_pull,
    output logic [DATA_W-1:0] o_sample_data,
    output logic              o_sample_valid,
    input  logic              i_sample_ready,
    input  logic              i_clear_stats,
    output logic [UCNT_W-1:0] o_underrun_cnt,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StPresent,
        StGap
    } state_e;

    localparam logic [GAP_W-1:0]  GapOne  = GAP_W'(1);
    localparam logic [UCNT_W-1:0] UcntMax = '1;

    state_e            state_q, state_d, slot_state;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic [UCNT_W-1:0] ucnt_q;
    logic [DATA_W-1:0] data_q;
    logic              pull_q, valid_q, busy_q;
    logic              decide, underrun;

    // Where the next sample slot goes once the current one (and its gap) is done
    always_comb begin
        slot_state = StIdle;
        if (i_enable && !i_fifo_empty) begin
            slot_state = StReq;
        end else if (i_enable) begin
`ifdef TX_PACER_ZERO_FILL_EN
            slot_state = StPresent;
`else
            slot_state = StIdle;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        decide  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_enable && !i_fifo_empty) state_d = StReq;
            end
            StReq:  state_d = StWait;
            StWait: state_d = StPresent;
            StPresent: begin
                if (i_sample_ready) begin
                    if (i_sample_gap != '0) begin
                        state_d = StGap;
                    end else begin
                        decide  = 1'b1;
                        state_d = slot_state;
                    end
                end
            end
            StGap: begin
                if (!i_enable) begin
                    state_d = StIdle;
                end else if (gap_cnt_q == GapOne) begin
                    decide  = 1'b1;
                    state_d = slot_state;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign underrun = decide && i_enable && i_fifo_empty;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            ucnt_q    <= '0;
            data_q    <= '0;
            pull_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pull_q  <= (state_d == StReq);
            valid_q <= (state_d == StPresent);
            busy_q  <= (state_d != StIdle);

            if (state_q == StWait) begin
                data_q <= i_fifo_data;
            end
`ifdef TX_PACER_ZERO_FILL_EN
            else if (underrun) begin
                data_q <= '0;
            end
`endif

            if (state_q == StPresent && i_sample_ready) begin
                gap_cnt_q <= i_sample_gap;
            end else if (state_q == StGap) begin
                gap_cnt_q <= i_enable ? gap_cnt_q - GapOne : '0;
            end

            // Clear takes priority over a coincident underrun
            if (i_clear_stats) begin
                ucnt_q <= '0;
            end else if (underrun && ucnt_q != UcntMax) begin
                ucnt_q <= ucnt_q + UCNT_W'(1);
            end
        end
    end

    assign o_fifo_pull    = pull_q;
    assign o_sample_valid = valid_q;
    assign o_sample_data  = data_q;
    assign o_busy         = busy_q;
    assign o_underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_tx_sample_pacer.sv
// Directed bench for tx_sample_pacer: FIFO model, sample scoreboard, pacing and counter checks.
module tb_tx_sample_pacer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned GAP_W  = 4;
    localparam int unsigned UCNT_W = 8;

    logic              i_sys_clk = 1'b0;
    logic              i_rst;
    logic              i_enable;
    logic [GAP_W-1:0]  i_sample_gap;
    logic              i_fifo_empty;
    logic [DATA_W-1:0] i_fifo_data;
    logic              o_fifo_pull;
    logic [DATA_W-1:0] o_sample_data;
    logic              o_sample_valid;
    logic              i_sample_ready;
    logic              i_clear_stats;
    logic [UCNT_W-1:0] o_underrun_cnt;
    logic              o_busy;

    tx_sample_pacer #(
        .DATA_W(DATA_W),
        .GAP_W (GAP_W),
        .UCNT_W(UCNT_W)
    ) dut (
        .i_sys_clk     (i_sys_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_sample_gap  (i_sample_gap),
        .i_fifo_empty  (i_fifo_empty),
        .i_fifo_data   (i_fifo_data),
        .o_fifo_pull   (o_fifo_pull),
        .o_sample_data (o_sample_data),
        .o_sample_valid(o_sample_valid),
        .i_sample_ready(i_sample_ready),
        .i_clear_stats (i_clear_stats),
        .o_underrun_cnt(o_underrun_cnt),
        .o_busy        (o_busy)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int n_acc    = 0;
    int n_pull   = 0;
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int acc_t[$];
    int rise_t[$];
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [DATA_W-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
        i_fifo_empty = 1'b0;
    endtask

    // One clock: score any handshake at the edge, then model the FIFO read port
    task automatic tick();
        logic              acc;
        logic [DATA_W-1:0] acc_data;
        logic [DATA_W-1:0] exp_data;
        logic              nonempty;
        acc      = o_sample_valid && i_sample_ready;
        acc_data = o_sample_data;
        @(posedge i_sys_clk);
        #1;
        cycle++;
        if (acc) begin
            n_acc++;
            acc_t.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_sample", 64'(acc_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_data = exp_q.pop_front();
                check("sb_data", 64'(acc_data), 64'(exp_data));
            end
        end
        if (o_sample_valid && !prev_valid) rise_t.push_back(cycle);
        prev_valid = o_sample_valid;
        if (o_fifo_pull) begin
            n_pull++;
            nonempty = (fifo_q.size() != 0);
            check("pull_nonempty", 64'(nonempty), 64'd1);
            if (nonempty) i_fifo_data = fifo_q.pop_front();
            i_fifo_empty = (fifo_q.size() == 0);
        end
    endtask

    task automatic run_until_idle(input int target_acc, input int budget, input string tag);
        int n;
        n = 0;
        while (!(n_acc >= target_acc && !o_busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n;
        n = 0;
        while (!o_sample_valid && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check(tag, 64'd0, 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 64'(o_sample_valid), 64'd0);
        check({tag, "_pull"}, 64'(o_fifo_pull), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
        check({tag, "_ucnt"}, 64'(o_underrun_cnt), 64'd0);
        check({tag, "_data"}, 64'(o_sample_data), 64'd0);
    endtask

    initial begin
        int a0, p0, t0, r0, n;

        i_rst          = 1'b1;
        i_enable       = 1'b0;
        i_sample_gap   = '0;
        i_fifo_empty   = 1'b1;
        i_fifo_data    = '0;
        i_sample_ready = 1'b1;
        i_clear_stats  = 1'b0;
        tick();
        tick();
        check_idle_outputs("por");
        i_rst = 1'b0;
        tick();

        // Gap 0 stream of three, then an underrun
        a0 = n_acc; p0 = n_pull; t0 = acc_t.size();
        load(32'h11); load(32'h22); load(32'h33);
        i_enable = 1'b1;
        run_until_idle(a0 + 3, 40, "stream_timeout");
        check("stream_pulls", 64'(n_pull - p0), 64'd3);
        if (acc_t.size() >= t0 + 3) begin
            check("stream_space1", 64'(acc_t[t0+1] - acc_t[t0]), 64'd3);
            check("stream_space2", 64'(acc_t[t0+2] - acc_t[t0+1]), 64'd3);
        end
        check("stream_ucnt", 64'(o_underrun_cnt), 64'd1);
        check("stream_busy", 64'(o_busy), 64'd0);
        check("stream_sb_empty", 64'(exp_q.size()), 64'd0);

        // Gap 5, changed to 2 while the first gap runs
        i_sample_gap = 4'd5;
        a0 = n_acc; r0 = rise_t.size();
        load(32'hA1); load(32'hA2); load(32'hA3); load(32'hA4);
        n = 0;
        while (n_acc == a0 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("gap_first_timeout", 64'd0, 64'd1);
        tick();
        tick();
        i_sample_gap = 4'd2;
        run_until_idle(a0 + 4, 80, "gap_timeout");
        if (rise_t.size() >= r0 + 4) begin
            check("gap_rise_5", 64'(rise_t[r0+1] - rise_t[r0]), 64'd8);
            check("gap_rise_2a", 64'(rise_t[r0+2] - rise_t[r0+1]), 64'd5);
            check("gap_rise_2b", 64'(rise_t[r0+3] - rise_t[r0+2]), 64'd5);
        end else begin
            check("gap_rise_count", 64'(rise_t.size() - r0), 64'd4);
        end
        check("gap_ucnt", 64'(o_underrun_cnt), 64'd2);

        // Backpressure with enable dropped during PRESENT
        i_sample_gap   = '0;
        i_sample_ready = 1'b0;
        p0 = n_pull;
        load(32'hDEADBEEF);
        wait_valid(10, "bp_valid_timeout");
        p0 = n_pull;
        for (int i = 0; i < 10; i++) begin
            check("bp_data", 64'(o_sample_data), 64'hDEADBEEF);
            check("bp_valid", 64'(o_sample_valid), 64'd1);
            check("bp_pull", 64'(o_fifo_pull), 64'd0);
            if (i == 4) i_enable = 1'b0;
            tick();
        end
        check("bp_no_pull", 64'(n_pull - p0), 64'd0);
        a0 = n_acc;
        i_sample_ready = 1'b1;
        tick();
        check("bp_accepted", 64'(n_acc - a0), 64'd1);
        check("bp_busy", 64'(o_busy), 64'd0);
        check("bp_ucnt", 64'(o_underrun_cnt), 64'd2);

        // Saturation: 260 single-sample underruns starting from 2
        i_enable = 1'b1;
        for (int i = 0; i < 260; i++) begin
            load(DATA_W'(32'h1000 + i));
            run_until_idle(n_acc + 1, 20, "sat_timeout");
            if (i == 251) check("sat_ucnt_254", 64'(o_underrun_cnt), 64'd254);
        end
        check("sat_ucnt_max", 64'(o_underrun_cnt), 64'd255);

        // Clear coincident with an underrun
        i_sample_ready = 1'b0;
        load(32'h5A5A0001);
        wait_valid(10, "clr_valid_timeout");
        i_clear_stats  = 1'b1;
        i_sample_ready = 1'b1;
        tick();
        i_clear_stats = 1'b0;
        check("clr_ucnt", 64'(o_underrun_cnt), 64'd0);
        check("clr_busy", 64'(o_busy), 64'd0);
        load(32'h77);
        run_until_idle(n_acc + 1, 20, "clr_resume_timeout");
        check("clr_resume_ucnt", 64'(o_underrun_cnt), 64'd1);

        // Asynchronous reset in the middle of PRESENT
        i_sample_ready = 1'b0;
        load(32'hA5A5A5A5);
        wait_valid(10, "rst_valid_timeout");
        check("rst_pre_data", 64'(o_sample_data), 64'hA5A5A5A5);
        i_rst = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        exp_q.delete();
        tick();
        i_rst = 1'b0;
        i_enable = 1'b0;
        tick();
        check("rst_after_busy", 64'(o_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
